branch_predict_ctrl: RTL
========================

// Module: branch_predict_ctrl
// PURPOSE
//   Dynamic conditional-branch predictor and mispredict recovery controller for the 5-stage pipeline.
//   - F/D decode queries it for bne/blt/bex and gets a taken/not-taken guess.
//   - Predicted branches are tracked in order until execute resolves them.
//   - On mispredict: trains a table of 2-bit saturating counters, then drives a flush and the corrected PC.
// PARAMETERS
//   IDX_BITS      6  log2 of counter-table entries; table indexed by lookup_pc[IDX_BITS-1:0]
//   DEPTH_BITS    2  log2 of in-flight queue depth (default 4 unresolved branches)
//   FLUSH_CYCLES  2  cycles flush is held after a mispredict (covers F and D stages)
// PORTS
//   clock            in   1   single clock, all state updates on rising edge
//   reset_n          in   1   synchronous, active-low reset
//   lookup_valid     in   1   decode holds a conditional branch (bne/blt/bex) this cycle
//   lookup_pc        in   32  PC of that branch (word-addressed)
//   lookup_target    in   32  computed branch target (pc+1+imm, or T for bex)
//   lookup_accept    out  1   branch enqueued this cycle
//   predict_taken    out  1   prediction for lookup_pc, combinational
//   stall            out  1   queue full; decode must hold
//   resolve_valid    in   1   execute resolved the oldest in-flight branch
//   resolve_taken    in   1   actual outcome of that branch
//   flush            out  1   squash F/D contents; registered
//   redirect_pc      out  32  corrected fetch PC; valid while flush=1; registered
//   inflight_count   out  DEPTH_BITS+1  number of queued unresolved branches
//   mispredict_count out  32  performance counter, wraps at 2^32
// BEHAVIOUR
//   Reset (reset_n=0 at edge)
//   - All counters set to 2'b01 (weakly not-taken).
//   - Queue emptied; state=RUN.
//   - flush=0, redirect_pc=0, mispredict_count=0, inflight_count=0.
//   - Applies mid-flush and mid-queue; no partial state survives.
//   Prediction
//   - predict_taken = table[lookup_pc[IDX_BITS-1:0]][1], combinational, 0 latency.
//   Queue
//   - FIFO of {pc, target, predicted}.
//   - stall = (inflight_count == 2^DEPTH_BITS).
//   - lookup_accept = lookup_valid & ~stall & state==RUN.
//   - A pop in the same cycle does NOT free space for a push while full; decode stalls one cycle.
//   - Push and pop in the same cycle (not full): count unchanged; pointers wrap modulo 2^DEPTH_BITS.
//   Resolve
//   - Accepted only in RUN with queue non-empty.
//   - resolve_valid on an empty queue, or in FLUSH, is ignored: no training, no counter change.
//   - On accept: pop head and train table[head.pc index].
//     - Taken: increment, saturating at 11.
//     - Not taken: decrement, saturating at 00.
//   - Same-cycle lookup and training of the same index: lookup reads the pre-update value.
//   Mispredict (accepted resolve with resolve_taken != head.predicted)
//   - Next edge: state -> FLUSH, flush=1, redirect_pc = resolve_taken ? head.target : head.pc+1 (32-bit wrap).
//   - mispredict_count increments on the same edge.
//   - Whole queue cleared, since all younger entries are wrong-path; any same-cycle lookup is dropped (lookup_accept=0).
//   State machine RUN/FLUSH
//   - RUN -> FLUSH on mispredict.
//   - FLUSH holds exactly FLUSH_CYCLES cycles, then -> RUN with flush=0.
//   - redirect_pc is held constant throughout FLUSH.
//   - In FLUSH: lookup_accept=0 and resolves are ignored.
//   Correct prediction: pop and train only; no flush.
// TESTING
//   1. Reset, lookup_pc=5 -> predict_taken=0, inflight_count=0, flush=0, mispredict_count=0.
//   2. Push pc=5 (predicted 0), resolve_taken=1
//      -> next cycle flush=1 for 2 cycles, redirect_pc=target, mispredict_count=1.
//      -> afterwards lookup pc=5 predicts 1.
//   3. Push pc=8 three times, resolve each taken -> counter saturates at 11; a not-taken resolve -> 10, still predicts taken.
//   4. Push 4 branches without resolve -> stall=1, 5th lookup_accept=0; resolve head correctly -> count 3, next cycle accept=1.
//   5. 3 queued, oldest (predicted 0, target=40) mispredicts as taken while a lookup arrives
//      -> queue cleared, lookup dropped, redirect_pc=40.
//   6. Resolve on empty queue -> no state change; reset_n=0 during FLUSH -> flush=0 and table back to 01 on the next edge.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_ctrl
// Purpose  : Dynamic conditional-branch predictor with mispredict recovery.
//            Decode queries a table of 2-bit saturating counters for a
//            taken/not-taken guess on bne/blt/bex. Predicted branches are
//            held in order in a small FIFO until execute resolves the oldest
//            one. Each resolve trains the counter of that branch. A wrong
//            guess clears the FIFO, holds flush for FLUSH_CYCLES cycles and
//            drives the corrected fetch PC.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clock            in   single clock, rising-edge
//   reset_n          in   synchronous, active-low reset
//   lookup_valid     in   decode holds a conditional branch this cycle
//   lookup_pc        in   word-address PC of that branch
//   lookup_target    in   computed branch target
//   lookup_accept    out  branch enqueued this cycle
//   predict_taken    out  prediction for lookup_pc (combinational)
//   stall            out  queue full, decode must hold
//   resolve_valid    in   execute resolved the oldest in-flight branch
//   resolve_taken    in   actual outcome of that branch
//   flush            out  squash F/D contents (registered)
//   redirect_pc      out  corrected fetch PC, valid while flush=1 (registered)
//   inflight_count   out  number of queued unresolved branches
//   mispredict_count out  mispredict performance counter, wraps at 2^32
// ============================================================================
module branch_predict_ctrl #(
   parameter int IDX_BITS     = 6,
   parameter int DEPTH_BITS   = 2,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  lookup_valid,
   input  logic [31:0]           lookup_pc,
   input  logic [31:0]           lookup_target,
   output logic                  lookup_accept,
   output logic                  predict_taken,
   output logic                  stall,
   input  logic                  resolve_valid,
   input  logic                  resolve_taken,
   output logic                  flush,
   output logic [31:0]           redirect_pc,
   output logic [DEPTH_BITS:0]   inflight_count,
   output logic [31:0]           mispredict_count
);

   localparam int c_TABLE_SIZE = 1 << IDX_BITS;
   localparam int c_QDEPTH     = 1 << DEPTH_BITS;
   // Flush down-counter only has to hold FLUSH_CYCLES-1.
   localparam int c_FCW        = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   // Prediction table and in-flight FIFO storage
   logic [1:0]            r_table  [c_TABLE_SIZE];
   logic [31:0]           r_qPc    [c_QDEPTH];
   logic [31:0]           r_qTarget[c_QDEPTH];
   logic                  r_qPred  [c_QDEPTH];
   logic [DEPTH_BITS-1:0] r_head;
   logic [DEPTH_BITS-1:0] r_tail;
   logic [DEPTH_BITS:0]   r_count;

   // Recovery state
   state_t                r_state;
   logic [c_FCW-1:0]      r_flushCnt;
   logic                  r_flush;
   logic [31:0]           r_redirectPc;
   logic [31:0]           r_mispredictCount;

   logic                  w_run;
   logic                  w_full;
   logic                  w_resolveAcc;
   logic                  w_mispredict;
   logic                  w_push;
   logic [IDX_BITS-1:0]   w_trainIdx;
   logic [1:0]            w_trainOld;
   logic [1:0]            w_trainNew;
   logic                  w_unusedPcBits;

   assign w_run        = (r_state == ST_RUN);
   assign w_full       = (r_count == (DEPTH_BITS+1)'(c_QDEPTH));
   assign w_resolveAcc = resolve_valid & w_run & (r_count != '0);
   assign w_mispredict = w_resolveAcc & (resolve_taken != r_qPred[r_head]);
   // A pop does not free a slot for a same-cycle push when full (w_full is
   // the pre-pop view), and a mispredict drops the lookup as wrong-path.
   assign w_push       = lookup_valid & ~w_full & w_run & ~w_mispredict;

   assign w_trainIdx   = r_qPc[r_head][IDX_BITS-1:0];
   assign w_trainOld   = r_table[w_trainIdx];

   always_comb begin
      w_trainNew = w_trainOld;
      if (resolve_taken) begin
         if (w_trainOld != 2'b11) w_trainNew = w_trainOld + 2'b01;
      end else begin
         if (w_trainOld != 2'b00) w_trainNew = w_trainOld - 2'b01;
      end
   end

   // Table read sees the pre-update value when training hits the same index.
   assign predict_taken    = r_table[lookup_pc[IDX_BITS-1:0]][1];
   assign lookup_accept    = w_push;
   assign stall            = w_full;
   assign flush            = r_flush;
   assign redirect_pc      = r_redirectPc;
   assign inflight_count   = r_count;
   assign mispredict_count = r_mispredictCount;

   // Upper PC bits take no part in indexing.
   assign w_unusedPcBits   = ^lookup_pc[31:IDX_BITS];

   // Counter table: reset to weakly not-taken, trained on every accepted resolve
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < c_TABLE_SIZE; i++) begin
            r_table[i] <= 2'b01;
         end
      end else if (w_resolveAcc) begin
         r_table[w_trainIdx] <= w_trainNew;
      end
   end

   // FIFO pointers and occupancy; a mispredict discards every younger entry
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (w_mispredict) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)       r_tail <= r_tail + 1'b1;
         if (w_resolveAcc) r_head <= r_head + 1'b1;
         if (w_push && !w_resolveAcc) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_resolveAcc) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // FIFO payload needs no reset: only slots behind valid pointers are read.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_qPc[r_tail]     <= lookup_pc;
         r_qTarget[r_tail] <= lookup_target;
         r_qPred[r_tail]   <= predict_taken;
      end
   end

   // RUN/FLUSH recovery machine with registered flush/redirect outputs
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state           <= ST_RUN;
         r_flush           <= 1'b0;
         r_flushCnt        <= '0;
         r_redirectPc      <= '0;
         r_mispredictCount <= '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_mispredict) begin
                  r_state           <= ST_FLUSH;
                  r_flush           <= 1'b1;
                  r_flushCnt        <= c_FCW'(FLUSH_CYCLES - 1);
                  r_redirectPc      <= resolve_taken ? r_qTarget[r_head]
                                                     : r_qPc[r_head] + 32'd1;
                  r_mispredictCount <= r_mispredictCount + 32'd1;
               end
            end
            ST_FLUSH: begin
               if (r_flushCnt == '0) begin
                  r_state <= ST_RUN;
                  r_flush <= 1'b0;
               end else begin
                  r_flushCnt <= r_flushCnt - 1'b1;
               end
            end
            default: begin
               r_state <= ST_RUN;
               r_flush <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
